// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage register chain with per-stage valid bits, valid/ready
// back-pressure, bubble collapsing and a synchronous flush.
module pipe_stage_chain #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH-1:0] en;

  // Ready chain walks from the output back toward the input: a stage may load
  // when it is empty or when everything ahead of it is also moving.
  always_comb begin
    logic chain;
    chain = out_ready;
    en    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain = !vld[k] || chain;
      en[k] = chain;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             up_vld;
      logic [WIDTH-1:0] up_dat;
      logic             vld_d, vld_q;
      logic [WIDTH-1:0] dat_d, dat_q;

      if (gi == 0) begin : g_head
        assign up_vld = in_valid;
        assign up_dat = in_data;
      end else begin : g_body
        assign up_vld = vld[gi-1];
        assign up_dat = dat[gi-1];
      end

      // Data only moves when a real entry arrives, so squashed or empty slots
      // keep their last payload.
      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
          vld_d = 1'b0;
        end else if (en[gi]) begin
          vld_d = up_vld;
          if (up_vld) begin
            dat_d = up_dat;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= 1'b0;
          dat_q <= RESET_VAL;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign vld[gi] = vld_q;
      assign dat[gi] = dat_q;
    end
  endgenerate

  always_comb begin
    logic [CW-1:0] sum;
    sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sum = sum + CW'(vld[k]);
    end
    count = sum;
  end

  assign in_ready  = en[0] && !flush;
  assign out_valid = vld[DEPTH-1] && !flush;
  assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a DEPTH=3/WIDTH=8 instance checked against an
// entry-position model, and a DEPTH=1/WIDTH=32 instance checked as a 1-deep FIFO.
module tb_pipe_stage_chain;

  localparam int          DA  = 3;
  localparam logic [7:0]  RVA = 8'h5A;
  localparam logic [31:0] RVB = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [7:0]  a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        rst_b, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [0:0]  b_count;

  pipe_stage_chain #(.WIDTH(8), .DEPTH(DA), .RESET_VAL(RVA)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(a_flush), .count(a_count)
  );

  pipe_stage_chain #(.WIDTH(32), .DEPTH(1), .RESET_VAL(RVB)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(b_flush), .count(b_count)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model A: ordered list of in-flight entries (oldest first) with their slot
  // positions. Each cycle every entry steps one slot forward unless it would
  // land on or pass the entry ahead of it; the oldest may leave from the last slot.
  int         mp[$];
  logic [7:0] md[$];
  int         np[$];
  logic [7:0] nd[$];

  task automatic plan(input logic ordy);
    int lim, p;
    np.delete();
    nd.delete();
    lim = DA - 1;
    for (int i = 0; i < mp.size(); i++) begin
      if (i == 0 && mp[0] == DA - 1 && ordy) continue;
      p = (mp[i] + 1 < lim) ? mp[i] + 1 : lim;
      np.push_back(p);
      nd.push_back(md[i]);
      lim = p - 1;
    end
  endtask

  // Model B: plain FIFO of capacity one.
  logic [31:0] bq[$];
  logic [31:0] b_next_exp;
  logic        a_rdy_m, b_rdy_m;

  always @(negedge rst_a) begin
    mp.delete();
    md.delete();
  end
  always @(negedge rst_b) bq.delete();

  always @(posedge clk) begin
    if (rst_a) begin
      plan(a_out_ready);
      a_rdy_m = !a_flush && (np.size() == 0 || np[np.size()-1] >= 1);
      if (a_flush) begin
        mp.delete();
        md.delete();
      end else begin
        if (a_in_valid && a_rdy_m) begin
          np.push_back(0);
          nd.push_back(a_in_data);
        end
        mp = np;
        md = nd;
      end
    end
    if (rst_b) begin
      if (b_flush) bq.delete();
      else begin
        b_rdy_m = (bq.size() == 0) || b_out_ready;
        if (bq.size() > 0 && b_out_ready) void'(bq.pop_front());
        if (b_in_valid && b_rdy_m) bq.push_back(b_in_data);
      end
    end
  end

  // Single compare process, away from the active edge.
  logic exp_rdy, exp_ov;
  always @(negedge clk) begin
    plan(a_out_ready);
    exp_rdy = !a_flush && (np.size() == 0 || np[np.size()-1] >= 1);
    exp_ov  = !a_flush && mp.size() > 0 && mp[0] == DA - 1;
    chk("a_in_ready", 32'(a_in_ready), 32'(exp_rdy));
    chk("a_out_valid", 32'(a_out_valid), 32'(exp_ov));
    chk("a_count", 32'(a_count), 32'(mp.size()));
    if (exp_ov) chk("a_out_data", 32'(a_out_data), 32'(md[0]));
    if (!rst_a) chk("a_reset_data", 32'(a_out_data), 32'(RVA));

    exp_rdy = !b_flush && (bq.size() == 0 || b_out_ready);
    exp_ov  = !b_flush && bq.size() > 0;
    chk("b_in_ready", 32'(b_in_ready), 32'(exp_rdy));
    chk("b_out_valid", 32'(b_out_valid), 32'(exp_ov));
    chk("b_count", 32'(b_count), 32'(bq.size()));
    if (!b_flush) chk("b_ready_rule", 32'(b_in_ready), 32'(!b_out_valid || b_out_ready));
    if (exp_ov) chk("b_out_data", b_out_data, bq[0]);
    if (exp_ov && b_out_ready) begin
      chk("b_order", b_out_data, b_next_exp);
      b_next_exp = b_next_exp + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_a(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
  endtask

  logic [31:0] b_data;
  logic        acc;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    set_a(1'b0, 8'h00, 1'b0, 1'b0);
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    b_next_exp = 32'd1;
    step(); step();
    settle();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'(RVA));
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_out_data", b_out_data, RVB);
    rst_a = 1'b1; rst_b = 1'b1;
    step();

    // Streaming at full rate
    set_a(1'b1, 8'h11, 1'b1, 1'b0); step();
    set_a(1'b1, 8'h22, 1'b1, 1'b0); step();
    set_a(1'b1, 8'h33, 1'b1, 1'b0); step();
    settle();
    chk("stream_first_valid", 32'(a_out_valid), 32'd1);
    chk("stream_first_data", 32'(a_out_data), 32'h11);
    chk("stream_count", 32'(a_count), 32'd3);
    set_a(1'b1, 8'h44, 1'b1, 1'b0); step(); settle();
    chk("stream_second_data", 32'(a_out_data), 32'h22);
    chk("stream_count2", 32'(a_count), 32'd3);
    set_a(1'b0, 8'h00, 1'b1, 1'b0); step(); settle();
    chk("stream_third_data", 32'(a_out_data), 32'h33);
    step(); step(); settle();
    chk("stream_drained", 32'(a_count), 32'd0);

    // Back-pressure fill
    set_a(1'b1, 8'hA1, 1'b0, 1'b0); step();
    set_a(1'b1, 8'hA2, 1'b0, 1'b0); step();
    set_a(1'b1, 8'hA3, 1'b0, 1'b0); step();
    set_a(1'b1, 8'hA4, 1'b0, 1'b0); settle();
    chk("bp_in_ready_low", 32'(a_in_ready), 32'd0);
    chk("bp_count_full", 32'(a_count), 32'd3);
    step(); settle();
    chk("bp_hold_data", 32'(a_out_data), 32'hA1);
    chk("bp_hold_count", 32'(a_count), 32'd3);
    set_a(1'b1, 8'hA4, 1'b1, 1'b0); settle();
    chk("bp_ready_on_pop", 32'(a_in_ready), 32'd1);
    step(); settle();
    chk("bp_pop_push_data", 32'(a_out_data), 32'hA2);
    chk("bp_pop_push_count", 32'(a_count), 32'd3);
    set_a(1'b0, 8'h00, 1'b1, 1'b0); step(); settle();
    chk("bp_drain_a3", 32'(a_out_data), 32'hA3);
    step(); settle();
    chk("bp_drain_a4", 32'(a_out_data), 32'hA4);
    step();

    // Bubble collapse under stall
    set_a(1'b1, 8'h01, 1'b0, 1'b0); step();
    set_a(1'b0, 8'h00, 1'b0, 1'b0); step();
    set_a(1'b1, 8'h02, 1'b0, 1'b0); step();
    set_a(1'b0, 8'h00, 1'b0, 1'b0); step(); settle();
    chk("bubble_count", 32'(a_count), 32'd2);
    chk("bubble_in_ready", 32'(a_in_ready), 32'd1);
    chk("bubble_first", 32'(a_out_data), 32'h01);
    set_a(1'b0, 8'h00, 1'b1, 1'b0); step(); settle();
    chk("bubble_second", 32'(a_out_data), 32'h02);
    step(); settle();
    chk("bubble_empty", 32'(a_count), 32'd0);

    // Flush with input and output both requesting
    set_a(1'b1, 8'hB1, 1'b0, 1'b0); step();
    set_a(1'b1, 8'hB2, 1'b0, 1'b0); step();
    set_a(1'b1, 8'hB3, 1'b0, 1'b0); step();
    set_a(1'b1, 8'hC0, 1'b1, 1'b1); settle();
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    chk("flush_in_ready", 32'(a_in_ready), 32'd0);
    step();
    set_a(1'b0, 8'h00, 1'b1, 1'b0); settle();
    chk("flush_count", 32'(a_count), 32'd0);
    for (int i = 0; i < 4; i++) step();
    settle();
    chk("flush_nothing_out", 32'(a_out_valid), 32'd0);

    // Asynchronous reset mid-stream
    set_a(1'b1, 8'h61, 1'b0, 1'b0); step();
    set_a(1'b1, 8'h62, 1'b0, 1'b0); step();
    set_a(1'b0, 8'h00, 1'b0, 1'b0); settle();
    chk("ar_count_before", 32'(a_count), 32'd2);
    #1 rst_a = 1'b0;
    #1;
    chk("ar_out_valid", 32'(a_out_valid), 32'd0);
    chk("ar_count", 32'(a_count), 32'd0);
    chk("ar_out_data", 32'(a_out_data), 32'(RVA));
    chk("ar_in_ready", 32'(a_in_ready), 32'd1);
    step();
    rst_a = 1'b1;
    set_a(1'b1, 8'h77, 1'b1, 1'b0); step();
    set_a(1'b0, 8'h00, 1'b1, 1'b0); settle();
    chk("ar_latency_early", 32'(a_out_valid), 32'd0);
    step(); step(); settle();
    chk("ar_latency_valid", 32'(a_out_valid), 32'd1);
    chk("ar_latency_data", 32'(a_out_data), 32'h77);
    step(); settle();
    chk("ar_latency_gone", 32'(a_out_valid), 32'd0);

    // Randomized traffic on the DEPTH=3 chain
    for (int i = 0; i < 500; i++) begin
      set_a($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      step();
    end
    set_a(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();

    // DEPTH=1: continuous pushes, out_ready alternating
    b_data = 32'd1;
    for (int i = 0; i < 80; i++) begin
      b_in_valid  = 1'b1;
      b_in_data   = b_data;
      b_out_ready = (i % 2 == 0);
      settle();
      acc = b_in_ready;
      step();
      if (acc) b_data = b_data + 1;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    settle();
    chk("b_all_delivered", b_next_exp, b_data);
    chk("b_empty_end", 32'(b_out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
